// File: rtl/xor_scan_acc_if.sv
// rtl/xor_scan_acc_if.sv - input/output valid-ready stream bundle for xor_scan_acc
interface xor_scan_acc_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/xor_scan_acc.sv
// rtl/xor_scan_acc.sv - streaming XOR accumulator with scan and frame-checksum modes
module xor_scan_acc #(
    parameter int W         = 8,
    parameter int FRAME_LEN = 4,
    parameter int INCLUSIVE = 0
) (
    input  logic         clk,
    input  logic         rst,
    xor_scan_acc_if.slave s,
    input  logic         mode,
    input  logic         clr,
    output logic [W-1:0] acc
);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt;
    logic          mode_q;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic          out_last_q;

    logic          in_ready_c;
    logic          accept;
    logic          frame_end;
    logic          load;
    logic [W-1:0]  nxt;

    assign in_ready_c = !clr && (!out_valid_q || s.out_ready);
    assign accept     = s.in_valid && in_ready_c;
    assign nxt        = acc ^ s.in_data;
    assign frame_end  = mode_q && (cnt == LAST);
    // Scan mode produces a word per accept; frame mode only on the closing word.
    assign load       = accept && (!mode_q || frame_end);

    assign s.in_ready  = in_ready_c;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            cnt         <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (clr) begin
                acc    <= '0;
                cnt    <= '0;
                mode_q <= mode;
            end else if (accept) begin
                if (!mode_q) begin
                    acc <= nxt;
                end else if (frame_end) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= nxt;
                    cnt <= cnt + 1'b1;
                end
            end

            // A load on a release cycle simply overwrites, keeping out_valid high.
            if (load) begin
                out_valid_q <= 1'b1;
                out_last_q  <= mode_q;
                if (mode_q || (INCLUSIVE != 0))
                    out_data_q <= nxt;
                else
                    out_data_q <= acc;
            end else if (out_valid_q && s.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xor_scan_acc.sv
// tb/tb_xor_scan_acc.sv - directed self-checking bench for xor_scan_acc (exclusive and inclusive)
module tb_xor_scan_acc;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] acc_x;
    logic [7:0] acc_i;
    int         checks = 0;
    int         failures = 0;

    xor_scan_acc_if #(.W(8)) bx ();
    xor_scan_acc_if #(.W(8)) bi ();

    xor_scan_acc #(.W(8), .FRAME_LEN(4), .INCLUSIVE(0)) dut_x (
        .clk(clk), .rst(rst), .s(bx), .mode(mode), .clr(clr), .acc(acc_x)
    );
    xor_scan_acc #(.W(8), .FRAME_LEN(4), .INCLUSIVE(1)) dut_i (
        .clk(clk), .rst(rst), .s(bi), .mode(mode), .clr(clr), .acc(acc_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        bx.in_valid = v;
        bx.in_data  = d;
        bi.in_valid = v;
        bi.in_data  = d;
    endtask

    task automatic set_ready(input logic r);
        bx.out_ready = r;
        bi.out_ready = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, d);
        cyc();
    endtask

    initial begin
        drive(1'b0, 8'h00);
        set_ready(1'b1);
        #1;
        chk("rst_out_valid", bx.out_valid, 1'b0);
        chk("rst_out_data", bx.out_data, 8'h00);
        chk("rst_out_last", bx.out_last, 1'b0);
        chk("rst_acc", acc_x, 8'h00);
        #6;
        rst = 1'b1;

        // scan mode, exclusive vs inclusive
        send(8'h01);
        chk("scan0_valid", bx.out_valid, 1'b1);
        chk("scan0_x", bx.out_data, 8'h00);
        chk("scan0_i", bi.out_data, 8'h01);
        chk("scan0_last", bx.out_last, 1'b0);
        send(8'h02);
        chk("scan1_x", bx.out_data, 8'h01);
        chk("scan1_i", bi.out_data, 8'h03);
        send(8'h04);
        chk("scan2_x", bx.out_data, 8'h03);
        chk("scan2_i", bi.out_data, 8'h07);
        chk("scan2_valid", bx.out_valid, 1'b1);
        drive(1'b0, 8'h00);
        cyc();
        chk("scan_release", bx.out_valid, 1'b0);
        chk("scan_acc_x", acc_x, 8'h07);
        chk("scan_acc_i", acc_i, 8'h07);

        // frame mode
        clr = 1'b1; mode = 1'b1;
        drive(1'b1, 8'hAA);
        #1;
        chk("clr_in_ready", bx.in_ready, 1'b0);
        cyc();
        clr = 1'b0;
        chk("clr_acc", acc_x, 8'h00);
        send(8'h11);
        send(8'h22);
        send(8'h44);
        chk("frame_nooutput", bx.out_valid, 1'b0);
        chk("frame_acc_mid", acc_x, 8'h77);
        send(8'h88);
        chk("frame_valid", bx.out_valid, 1'b1);
        chk("frame_data", bx.out_data, 8'hFF);
        chk("frame_last", bx.out_last, 1'b1);
        chk("frame_data_i", bi.out_data, 8'hFF);
        chk("frame_acc0", acc_x, 8'h00);
        send(8'hFF);
        chk("frame2_released", bx.out_valid, 1'b0);
        send(8'hFF);
        send(8'hFF);
        chk("frame2_nooutput", bx.out_valid, 1'b0);
        send(8'hFF);
        chk("frame2_valid", bx.out_valid, 1'b1);
        chk("frame2_data", bx.out_data, 8'h00);
        chk("frame2_last", bx.out_last, 1'b1);

        // backpressure in scan mode
        drive(1'b0, 8'h00);
        clr = 1'b1; mode = 1'b0;
        cyc();
        clr = 1'b0;
        chk("bp_idle", bx.out_valid, 1'b0);
        set_ready(1'b0);
        drive(1'b1, 8'h05);
        #1;
        chk("bp_ready0", bx.in_ready, 1'b1);
        cyc();
        chk("bp_valid", bx.out_valid, 1'b1);
        chk("bp_data0", bx.out_data, 8'h00);
        chk("bp_last0", bx.out_last, 1'b0);
        drive(1'b1, 8'h0A);
        #1;
        chk("bp_blocked", bx.in_ready, 1'b0);
        cyc();
        chk("bp_hold_data", bx.out_data, 8'h00);
        chk("bp_hold_valid", bx.out_valid, 1'b1);
        chk("bp_hold_acc", acc_x, 8'h05);
        set_ready(1'b1);
        #1;
        chk("bp_release_ready", bx.in_ready, 1'b1);
        cyc();
        chk("bp_data1", bx.out_data, 8'h05);
        chk("bp_valid1", bx.out_valid, 1'b1);
        chk("bp_data1_i", bi.out_data, 8'h0F);
        chk("bp_acc1", acc_x, 8'h0F);
        drive(1'b0, 8'h00);
        cyc();
        chk("bp_drain", bx.out_valid, 1'b0);

        // clear mid-frame, then mode toggle without clr
        clr = 1'b1; mode = 1'b1;
        cyc();
        clr = 1'b0;
        send(8'h0F);
        send(8'hF0);
        chk("cmf_acc", acc_x, 8'hFF);
        clr = 1'b1;
        drive(1'b1, 8'h55);
        #1;
        chk("cmf_in_ready", bx.in_ready, 1'b0);
        cyc();
        clr = 1'b0;
        chk("cmf_acc0", acc_x, 8'h00);
        chk("cmf_nooutput", bx.out_valid, 1'b0);
        mode = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h04);
        chk("cmf_mid", bx.out_valid, 1'b0);
        send(8'h08);
        chk("cmf_valid", bx.out_valid, 1'b1);
        chk("cmf_data", bx.out_data, 8'h0F);
        chk("cmf_last", bx.out_last, 1'b1);

        // async reset with accumulator mid-frame and held output fields nonzero
        send(8'h33);
        drive(1'b0, 8'h00);
        chk("ar_pre_acc", acc_x, 8'h33);
        chk("ar_pre_last", bx.out_last, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", bx.out_valid, 1'b0);
        chk("ar_data", bx.out_data, 8'h00);
        chk("ar_last", bx.out_last, 1'b0);
        chk("ar_acc", acc_x, 8'h00);
        #1;
        rst = 1'b1;
        send(8'h3C);
        chk("ar_post_valid", bx.out_valid, 1'b1);
        chk("ar_post_data", bx.out_data, 8'h00);
        chk("ar_post_last", bx.out_last, 1'b0);
        chk("ar_post_data_i", bi.out_data, 8'h3C);
        drive(1'b0, 8'h00);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
